// File: rtl/dcache_ctrl.sv
// Sequencing controller for a 16-line fully-associative, write-through, no-allocate data cache.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | ready for a request, captures address/we/data on cpu_req_valid
// LOOKUP | array compare on the captured tag, decides hit/miss path
// RD_MEM | load miss: memory read outstanding, bounded by the timeout timer
// FILL   | write fetched word into the victim way, mark it valid
// WR_UPD | store hit: update the matching way with store data
// WR_MEM | store: write-through to memory, bounded by the timeout timer
// RESP   | one-cycle response pulse to the CPU
module dcache_ctrl #(
    parameter int WAYS        = 16,
    parameter int TAG_W       = 29,
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 255,
    localparam int WW         = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_resp_err,
    output logic [1:0]        cache_status,
    output logic [TAG_W-1:0]  arr_tag,
    input  logic              arr_hit,
    input  logic [WW-1:0]     arr_hit_way,
    input  logic [DATA_W-1:0] arr_rdata,
    output logic              arr_we,
    output logic [WW-1:0]     arr_way,
    output logic [DATA_W-1:0] arr_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_MEM, FILL, WR_UPD, WR_MEM, RESP} stateT;

    stateT             stateQ, stateD;
    logic [31:0]       addrQ;
    logic              weQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;
    logic              errQ;
    logic [WW-1:0]     hitWayQ;
    logic [1:0]        statusQ;
    logic [WAYS-1:0]   validQ;
    logic [WW-1:0]     ptrQ;
    logic [7:0]        timerQ;

    logic              lookupHit;
    logic              allValid;
    logic [WW-1:0]     victimWay;
    logic              memTimeout;
    logic              memCur, memNext;

    assign lookupHit  = arr_hit & validQ[arr_hit_way];
    assign allValid   = &validQ;
    assign memTimeout = (timerQ == 8'd0);
    assign memCur     = (stateQ == RD_MEM) || (stateQ == WR_MEM);
    assign memNext    = (stateD == RD_MEM) || (stateD == WR_MEM);

    assign arr_tag      = addrQ[31 -: TAG_W];
    assign mem_addr     = addrQ;
    assign mem_wdata    = wdataQ;
    assign cpu_rdata    = rdataQ;
    assign cache_status = statusQ;

    // Lowest-index invalid way wins; round-robin pointer only once every way is valid.
    always_comb begin
        victimWay = ptrQ;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!validQ[i]) victimWay = WW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stateQ <= IDLE;
        else          stateQ <= stateD;
    end

    always_comb begin
        stateD         = stateQ;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_err   = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        arr_we         = 1'b0;
        arr_way        = '0;
        arr_wdata      = '0;
        case (stateQ)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) stateD = LOOKUP;
            end
            LOOKUP: begin
                if (weQ) stateD = lookupHit ? WR_UPD : WR_MEM;
                else     stateD = lookupHit ? RESP   : RD_MEM;
            end
            RD_MEM: begin
                mem_req = 1'b1;
                if (mem_ack)         stateD = FILL;
                else if (memTimeout) stateD = RESP;
            end
            FILL: begin
                arr_we    = 1'b1;
                arr_way   = victimWay;
                arr_wdata = rdataQ;
                stateD    = RESP;
            end
            WR_UPD: begin
                arr_we    = 1'b1;
                arr_way   = hitWayQ;
                arr_wdata = wdataQ;
                stateD    = WR_MEM;
            end
            WR_MEM: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack || memTimeout) stateD = RESP;
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_err   = errQ;
                stateD         = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addrQ   <= '0;
            weQ     <= 1'b0;
            wdataQ  <= '0;
            rdataQ  <= '0;
            errQ    <= 1'b0;
            hitWayQ <= '0;
            statusQ <= 2'b00;
            validQ  <= '0;
            ptrQ    <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (cpu_req_valid) begin
                        addrQ  <= cpu_addr;
                        weQ    <= cpu_req_we;
                        wdataQ <= cpu_wdata;
                        rdataQ <= '0;
                        errQ   <= 1'b0;
                    end
                end
                LOOKUP: begin
                    statusQ <= lookupHit ? 2'b01 : 2'b10;
                    if (lookupHit) hitWayQ <= arr_hit_way;
                    if (lookupHit && !weQ) rdataQ <= arr_rdata;
                end
                RD_MEM: begin
                    if (mem_ack) rdataQ <= mem_rdata;
                    else if (memTimeout) begin
                        rdataQ <= '0;
                        errQ   <= 1'b1;
                    end
                end
                WR_MEM: begin
                    if (!mem_ack && memTimeout) errQ <= 1'b1;
                end
                FILL: begin
                    validQ[victimWay] <= 1'b1;
                    if (allValid) ptrQ <= (ptrQ == WW'(WAYS - 1)) ? '0 : ptrQ + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Down-counter loaded on entry to a memory wait; expiry is the zero terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       timerQ <= 8'd0;
        else if (memNext && !memCur)        timerQ <= 8'(MEM_TIMEOUT - 1);
        else if (memCur && !memTimeout)     timerQ <= timerQ - 8'd1;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hitCntQ, missCntQ;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hitCntQ  <= '0;
            missCntQ <= '0;
        end else if (stateQ == LOOKUP) begin
            if (lookupHit) hitCntQ  <= hitCntQ + 32'd1;
            else           missCntQ <= missCntQ + 32'd1;
        end
    end

    assign hit_count  = hitCntQ;
    assign miss_count = missCntQ;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: driver pushes expected responses, memory requests and
// array writes into queues; independent monitors pop and compare when the DUT presents them.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_resp_valid, cpu_resp_err;
    logic [31:0] cpu_rdata;
    logic [1:0]  cache_status;
    logic [28:0] arr_tag;
    logic        arr_hit;
    logic [3:0]  arr_hit_way;
    logic [31:0] arr_rdata;
    logic        arr_we;
    logic [3:0]  arr_way;
    logic [31:0] arr_wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_resp_err(cpu_resp_err),
        .cache_status(cache_status),
        .arr_tag(arr_tag), .arr_hit(arr_hit), .arr_hit_way(arr_hit_way), .arr_rdata(arr_rdata),
        .arr_we(arr_we), .arr_way(arr_way), .arr_wdata(arr_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {int acc; int lat; logic err; logic [1:0] st; logic chk; logic [31:0] data;} respT;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int len;} memT;
    typedef struct {logic [3:0] way; logic [28:0] tag; logic [31:0] data;} arrT;

    respT respQ[$];
    memT  memQ[$];
    arrT  arrQ[$];

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int expHits = 0;
    int expMiss = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // External tag/data array: combinational lookup, written on arr_we.
    logic [28:0] mTag  [16];
    logic [31:0] mData [16];
    logic [15:0] mVal = '0;

    always @(posedge clk) begin
        if (arr_we) begin
            mTag[arr_way]  <= arr_tag;
            mData[arr_way] <= arr_wdata;
            mVal[arr_way]  <= 1'b1;
        end
    end

    always_comb begin
        arr_hit     = 1'b0;
        arr_hit_way = 4'd0;
        arr_rdata   = 32'd0;
        for (int i = 0; i < 16; i++) begin
            if (!arr_hit && mVal[i] && mTag[i] == arr_tag) begin
                arr_hit     = 1'b1;
                arr_hit_way = 4'(i);
                arr_rdata   = mData[i];
            end
        end
    end

    // Memory responder: ack after ackDelay extra cycles of mem_req, or never when noAck.
    int          ackDelay = 0;
    bit          noAck    = 1'b0;
    logic [31:0] memData  = 32'd0;

    initial begin
        int waitCnt;
        waitCnt   = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && !noAck) begin
                waitCnt++;
                if (waitCnt == ackDelay + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memData;
                    waitCnt   = 0;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Response monitor
    initial begin
        respT r;
        forever begin
            @(negedge clk);
            if (cpu_resp_valid) begin
                check("resp_expected", 32'(respQ.size() > 0), 32'd1);
                if (respQ.size() > 0) begin
                    r = respQ.pop_front();
                    check("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
                    check("resp_err", 32'(cpu_resp_err), 32'(r.err));
                    check("cache_status", 32'(cache_status), 32'(r.st));
                    if (r.chk) check("cpu_rdata", cpu_rdata, r.data);
                end
            end
        end
    end

    // Memory request monitor: fields on the first cycle, held-cycle count when it drops.
    initial begin
        memT  m;
        bit   act;
        int   len;
        logic stable;
        act = 1'b0;
        len = 0;
        stable = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_req && !act) begin
                act = 1'b1;
                len = 1;
                stable = 1'b1;
                check("mem_expected", 32'(memQ.size() > 0), 32'd1);
                if (memQ.size() > 0) begin
                    m = memQ.pop_front();
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_wdata", mem_wdata, m.wdata);
                end else begin
                    m.len = -1;
                end
            end else if (mem_req) begin
                len++;
                if (mem_addr !== m.addr || mem_wdata !== m.wdata) stable = 1'b0;
            end else if (act) begin
                act = 1'b0;
                if (m.len >= 0) begin
                    check("mem_req_cycles", 32'(len), 32'(m.len));
                    check("mem_stable", 32'(stable), 32'd1);
                end
            end
        end
    end

    // Array write monitor
    initial begin
        arrT a;
        forever begin
            @(negedge clk);
            if (arr_we) begin
                check("arr_we_expected", 32'(arrQ.size() > 0), 32'd1);
                if (arrQ.size() > 0) begin
                    a = arrQ.pop_front();
                    check("arr_way", 32'(arr_way), 32'(a.way));
                    check("arr_tag", 32'(arr_tag), 32'(a.tag));
                    check("arr_wdata", arr_wdata, a.data);
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while ((respQ.size() != 0 || memQ.size() != 0 || arrQ.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("txn_completed", 32'(n < 400), 32'd1);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic err, input logic [1:0] st,
                         input logic chk, input logic [31:0] data, input bit track);
        int   n = 0;
        respT r;
        @(negedge clk);
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_for_req", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        if (track) begin
            r.acc = cyc; r.lat = lat; r.err = err; r.st = st; r.chk = chk; r.data = data;
            respQ.push_back(r);
            if (st == 2'b01) expHits++;
            else             expMiss++;
        end
        @(negedge clk);
        cpu_req_valid = 1'b0;
        if (track) waitDrain();
    endtask

    task automatic pushMem(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int len);
        memT m;
        m.we = we; m.addr = addr; m.wdata = wdata; m.len = len;
        memQ.push_back(m);
    endtask

    task automatic pushArr(input logic [3:0] way, input logic [31:0] addr, input logic [31:0] data);
        arrT a;
        a.way = way; a.tag = addr[31:3]; a.data = data;
        arrQ.push_back(a);
    endtask

    // Load miss with d wait cycles: LOOKUP, RD_MEM x(d+1), FILL, RESP -> 4+d cycles.
    task automatic loadMiss(input logic [31:0] addr, input logic [31:0] d32, input int d, input logic [3:0] way);
        ackDelay = d; noAck = 1'b0; memData = d32;
        pushMem(1'b0, addr, 32'd0, d + 1);
        pushArr(way, addr, d32);
        issue(1'b0, addr, 32'd0, 4 + d, 1'b0, 2'b10, 1'b1, d32, 1'b1);
    endtask

    task automatic loadHit(input logic [31:0] addr, input logic [31:0] data);
        issue(1'b0, addr, 32'd0, 2, 1'b0, 2'b01, 1'b1, data, 1'b1);
    endtask

    // Store hit: LOOKUP, WR_UPD, WR_MEM x(d+1), RESP -> 4+d cycles.
    task automatic storeHit(input logic [31:0] addr, input logic [31:0] data, input int d, input logic [3:0] way);
        ackDelay = d; noAck = 1'b0;
        pushArr(way, addr, data);
        pushMem(1'b1, addr, data, d + 1);
        issue(1'b1, addr, data, 4 + d, 1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
    endtask

    // Store miss (no allocate): LOOKUP, WR_MEM x(d+1), RESP -> 3+d cycles.
    task automatic storeMiss(input logic [31:0] addr, input logic [31:0] data, input int d);
        ackDelay = d; noAck = 1'b0;
        pushMem(1'b1, addr, data, d + 1);
        issue(1'b1, addr, data, 3 + d, 1'b0, 2'b10, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n       = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_addr      = 32'd0;
        cpu_wdata     = 32'd0;
        #12;
        check("rst_ready", 32'(cpu_req_ready), 32'd1);
        check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_arr_we", 32'(arr_we), 32'd0);
        check("rst_status", 32'(cache_status), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Cold miss on 0x28 with one memory wait cycle -> way 0, 5 cycles.
        loadMiss(32'h28, 32'hDEADBEEF, 1, 4'd0);
        loadHit(32'h28, 32'hDEADBEEF);
        storeHit(32'h28, 32'h12345678, 0, 4'd0);
        loadHit(32'h28, 32'h12345678);
        storeMiss(32'h1000, 32'hCAFEF00D, 2);

        // Fill remaining ways in order, then all-valid round robin 0,1,2 and a full wrap.
        for (int i = 1; i < 16; i++)
            loadMiss(32'h1000_0000 + 32'(i * 8), 32'h5000_0000 + 32'(i), i % 3, 4'(i));
        for (int j = 0; j < 19; j++)
            loadMiss(32'h2000_0000 + 32'(j * 8), 32'h6000_0000 + 32'(j), j % 2, 4'(j % 16));
        loadHit(32'h2000_0090, 32'h6000_0012);

        // Timeout: 255 cycles of mem_req, error response, no fill; ptr stays at 3.
        noAck = 1'b1;
        pushMem(1'b0, 32'h3000_0000, 32'd0, 255);
        issue(1'b0, 32'h3000_0000, 32'd0, 257, 1'b1, 2'b10, 1'b1, 32'd0, 1'b1);
        loadMiss(32'h3000_0008, 32'h7777_0001, 0, 4'd3);
        loadHit(32'h2000_0090, 32'h6000_0012);
        storeMiss(32'h3000_0000, 32'h0BAD_0BAD, 0);

        check("stats_hits",
`ifdef DCACHE_STATS_EN
              hit_count, 32'(expHits));
`else
              hit_count, 32'd0);
`endif
        check("stats_misses",
`ifdef DCACHE_STATS_EN
              miss_count, 32'(expMiss));
`else
              miss_count, 32'd0);
`endif

        // Reset in the 4th RD_MEM cycle: mem_req drops at once, no response, no fill.
        noAck = 1'b1;
        pushMem(1'b0, 32'h4000_0000, 32'd0, 4);
        issue(1'b0, 32'h4000_0000, 32'd0, 0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_mem_reached", 32'(mem_req), 32'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check("rst_async_mem_req", 32'(mem_req), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        noAck   = 1'b0;
        expHits = 0;
        expMiss = 0;
        @(negedge clk);
        check("post_rst_ready", 32'(cpu_req_ready), 32'd1);
        check("post_rst_status", 32'(cache_status), 32'd0);
        check("post_rst_mem_drained", 32'(memQ.size()), 32'd0);

        // Array still holds this tag in way 5, but valid bits were cleared: miss into way 0.
        loadMiss(32'h2000_0028, 32'hABCD_1234, 0, 4'd0);
        loadHit(32'h2000_0028, 32'hABCD_1234);

        check("stats_hits_after_rst",
`ifdef DCACHE_STATS_EN
              hit_count, 32'(expHits));
`else
              hit_count, 32'd0);
`endif
        check("stats_misses_after_rst",
`ifdef DCACHE_STATS_EN
              miss_count, 32'(expMiss));
`else
              miss_count, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("resp_queue_empty", 32'(respQ.size()), 32'd0);
        check("arr_queue_empty", 32'(arrQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
